// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and sizes for the one-hot select-bus drive blocks
package decoder_pkg;
    localparam int IN_W = 3;
    localparam int OUT_W = 2**IN_W;
    localparam int HOLD_CNT_W = 8;
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
endpackage

// File: rtl/onehot_decoder_hold_if.sv
// onehot_decoder_hold_if: code handshake in, one-hot strobe out
interface onehot_decoder_hold_if #(parameter int IN_W = 3);
    logic in_valid;
    logic in_ready;
    logic [IN_W-1:0] in_code;
    logic cancel;
    logic [2**IN_W-1:0] out;
    logic out_valid;
    logic done;
    modport master(output in_valid, in_code, cancel, input in_ready, out, out_valid, done);
    modport slave(input in_valid, in_code, cancel, output in_ready, out, out_valid, done);
endinterface

// File: rtl/hold_counter.sv
// hold_counter: loadable down-counter that parks at zero
module hold_counter import decoder_pkg::*; #(parameter int W = HOLD_CNT_W) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/onehot_decoder_hold.sv
// onehot_decoder_hold: registered binary-to-one-hot strobe with hold time and a one-cycle gap
module onehot_decoder_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int IN_W = 3
) (
    input logic clk,
    input logic rst_n,
    onehot_decoder_hold_if.slave bus
);
    import decoder_pkg::*;
    localparam int out_w = 2**IN_W;
    state_t state;
    logic zero;
    logic take;
    logic dec;
    assign take = state == IDLE && bus.in_ready && bus.in_valid && !bus.cancel;
    assign dec = state == HOLD && !bus.cancel;
    hold_counter #(.W(HOLD_CNT_W)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .load(take),
        .load_val(HOLD_CNT_W'(HOLD_CYCLES - 1)),
        .dec(dec),
        .zero(zero)
    );
    // cancel on the last hold cycle must suppress done, so it gates the registered state here
    assign bus.done = bus.out_valid && zero && !bus.cancel;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            bus.out <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: if (take) begin
                    state <= HOLD;
                    bus.out <= {{(out_w-1){1'b0}}, 1'b1} << bus.in_code;
                    bus.out_valid <= 1'b1;
                    bus.in_ready <= 1'b0;
                end
                HOLD: if (bus.cancel || zero) begin
                    state <= GAP;
                    bus.out <= '0;
                    bus.out_valid <= 1'b0;
                end
                GAP: begin
                    state <= IDLE;
                    bus.in_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    bus.out <= '0;
                    bus.out_valid <= 1'b0;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
endmodule

// File: tb/tb_onehot_decoder_hold.sv
// tb_onehot_decoder_hold: directed checks of strobe timing, cancel, async reset and HOLD_CYCLES=1
module tb_onehot_decoder_hold;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    onehot_decoder_hold_if #(.IN_W(3)) b4();
    onehot_decoder_hold_if #(.IN_W(3)) b1();
    onehot_decoder_hold #(.HOLD_CYCLES(4), .IN_W(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    onehot_decoder_hold #(.HOLD_CYCLES(1), .IN_W(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // {in_ready, done, out_valid, out}
    function automatic logic [31:0] snap4();
        return {21'd0, b4.in_ready, b4.done, b4.out_valid, b4.out};
    endfunction
    function automatic logic [31:0] snap1();
        return {21'd0, b1.in_ready, b1.done, b1.out_valid, b1.out};
    endfunction
    function automatic logic [31:0] exp_s(input logic rdy, input logic dn, input logic vld, input logic [7:0] o);
        return {21'd0, rdy, dn, vld, o};
    endfunction
    initial begin
        b4.in_valid = 0; b4.in_code = 0; b4.cancel = 0;
        b1.in_valid = 0; b1.in_code = 0; b1.cancel = 0;
        #12 rst_n = 1'b1;
        tick;
        chk("reset", snap4(), exp_s(1, 0, 0, 8'h00));
        chk("reset_h1", snap1(), exp_s(1, 0, 0, 8'h00));
        b4.in_valid = 1; b4.in_code = 3'd5;
        tick;
        b4.in_valid = 0; b4.in_code = 3'd1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("code5_hold%0d", k), snap4(), exp_s(0, k == 3, 1, 8'h20));
            tick;
        end
        chk("code5_gap", snap4(), exp_s(0, 0, 0, 8'h00));
        tick;
        chk("code5_idle", snap4(), exp_s(1, 0, 0, 8'h00));
        b4.in_valid = 1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("sweep_ready%0d", c), snap4(), exp_s(1, 0, 0, 8'h00));
            b4.in_code = 3'(c);
            tick;
            b4.in_code = 3'(~c);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("sweep%0d_hold%0d", c, k), snap4(), exp_s(0, k == 3, 1, 8'(1 << c)));
                tick;
            end
            chk($sformatf("sweep%0d_gap", c), snap4(), exp_s(0, 0, 0, 8'h00));
            if (c == 7) b4.in_valid = 0;
            tick;
        end
        chk("sweep_end", snap4(), exp_s(1, 0, 0, 8'h00));
        b4.in_valid = 1; b4.in_code = 3'd2;
        tick;
        b4.in_valid = 0; b4.cancel = 1;
        chk("cancel_hold", snap4(), exp_s(0, 0, 1, 8'h04));
        tick;
        b4.cancel = 0;
        chk("cancel_gap", snap4(), exp_s(0, 0, 0, 8'h00));
        tick;
        chk("cancel_idle", snap4(), exp_s(1, 0, 0, 8'h00));
        b4.in_valid = 1; b4.in_code = 3'd3;
        tick;
        b4.in_valid = 0;
        tick; tick; tick;
        chk("last_hold_done", snap4(), exp_s(0, 1, 1, 8'h08));
        b4.cancel = 1;
        #1;
        chk("last_hold_cancel", snap4(), exp_s(0, 0, 1, 8'h08));
        tick;
        b4.cancel = 0;
        chk("last_cancel_gap", snap4(), exp_s(0, 0, 0, 8'h00));
        tick;
        chk("last_cancel_idle", snap4(), exp_s(1, 0, 0, 8'h00));
        b4.in_valid = 1; b4.in_code = 3'd7;
        tick;
        b4.in_valid = 0;
        tick;
        chk("pre_reset_hold", snap4(), exp_s(0, 0, 1, 8'h80));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", snap4(), exp_s(1, 0, 0, 8'h00));
        #1 rst_n = 1'b1;
        tick;
        chk("post_reset_idle", snap4(), exp_s(1, 0, 0, 8'h00));
        b4.in_valid = 1; b4.in_code = 3'd1;
        tick;
        b4.in_valid = 0;
        chk("post_reset_hold", snap4(), exp_s(0, 0, 1, 8'h02));
        tick; tick; tick;
        chk("post_reset_done", snap4(), exp_s(0, 1, 1, 8'h02));
        tick;
        chk("post_reset_gap", snap4(), exp_s(0, 0, 0, 8'h00));
        tick;
        chk("post_reset_ready", snap4(), exp_s(1, 0, 0, 8'h00));
        b1.in_valid = 1; b1.in_code = 3'd0;
        tick;
        b1.in_valid = 0;
        chk("h1_hold_done", snap1(), exp_s(0, 1, 1, 8'h01));
        tick;
        chk("h1_gap", snap1(), exp_s(0, 0, 0, 8'h00));
        tick;
        chk("h1_idle", snap1(), exp_s(1, 0, 0, 8'h00));
        b4.in_valid = 1; b4.cancel = 1; b4.in_code = 3'd4;
        tick;
        chk("idle_cancel1", snap4(), exp_s(1, 0, 0, 8'h00));
        tick;
        chk("idle_cancel2", snap4(), exp_s(1, 0, 0, 8'h00));
        b4.in_valid = 0; b4.cancel = 0;
        tick;
        chk("idle_cancel3", snap4(), exp_s(1, 0, 0, 8'h00));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
